// File: rtl/stream_out_downsizer_pkg.sv
// Shared widths, FSM state type and half-selection helpers for the 128->64 stream downsizer.
package stream_out_pkg;

  localparam int DW_IN  = 128;
  localparam int DW_OUT = DW_IN / 2;
  localparam int KW_IN  = DW_IN / 8;
  localparam int KW_OUT = DW_OUT / 8;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  // Byte-enable slice of one half of an input beat (hi=1 selects the upper half).
  function automatic logic [KW_OUT-1:0] keep_half(input logic [KW_IN-1:0] keep, input logic hi);
    logic [KW_OUT-1:0] half_s;
    if (hi) begin
      half_s = keep[KW_IN-1:KW_OUT];
    end else begin
      half_s = keep[KW_OUT-1:0];
    end
    return half_s;
  endfunction

  function automatic logic [DW_OUT-1:0] data_half(input logic [DW_IN-1:0] data, input logic hi);
    logic [DW_OUT-1:0] half_s;
    if (hi) begin
      half_s = data[DW_IN-1:DW_OUT];
    end else begin
      half_s = data[DW_OUT-1:0];
    end
    return half_s;
  endfunction

endpackage

// File: rtl/stream_out_downsizer_if.sv
// AXI4-Stream bundle (tdata/tvalid/tready/tkeep/tlast) with master and slave views.
interface stream_out_downsizer_if #(
  parameter int DW = 128
) ();

  localparam int KW = DW / 8;

  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic [KW-1:0] tkeep;
  logic          tlast;

  modport master (output tdata, output tvalid, output tkeep, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tkeep, input tlast, output tready);

endinterface

// File: rtl/stream_out_downsizer_stat_cnt.sv
// 32-bit wrapping event counter with a synchronous clear that wins over an increment.
module stream_stat_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_r;

  // Event count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 32'd0;
    end else if (clr) begin
      count_r <= 32'd0;
    end else if (inc) begin
      count_r <= count_r + 32'd1;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/stream_out_downsizer.sv
// Splits each 128-bit stream beat into one or two registered 64-bit beats, trimming empty upper halves.
// Optional beat/packet counters are built when STREAM_OUT_STAT_EN is defined.
module stream_out_downsizer #(
  parameter int DW_IN     = stream_out_pkg::DW_IN,
  parameter int LSB_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  stream_out_downsizer_if.slave  s,
  stream_out_downsizer_if.master m
`ifdef STREAM_OUT_STAT_EN
  ,
  input  logic                  stat_clr,
  output logic [31:0]           stat_beats_in,
  output logic [31:0]           stat_pkts_out
`endif
);

  localparam int HW  = DW_IN / 2;
  localparam int HKW = HW / 8;
  localparam int IKW = DW_IN / 8;
  localparam logic FIRST_HI = (LSB_FIRST == 0) ? 1'b1 : 1'b0;

  import stream_out_pkg::*;

  state_t state_r;
  state_t state_n_s;

  logic [DW_IN-1:0] hdata_r;
  logic [IKW-1:0]   hkeep_r;
  logic             hlast_r;
  logic             need_second_r;

  logic [HW-1:0]    m_tdata_r;
  logic [HKW-1:0]   m_tkeep_r;
  logic             m_tlast_r;

  logic [HKW-1:0]   in_first_keep_s;
  logic [HKW-1:0]   in_second_keep_s;
  logic             last_half_s;
  logic             s_tready_s;
  logic             accept_s;
  logic             drop_s;
  logic             m_hs_s;
  logic             load_first_s;
  logic             load_second_s;

  assign in_first_keep_s  = keep_half(s.tkeep, FIRST_HI);
  assign in_second_keep_s = keep_half(s.tkeep, ~FIRST_HI);

  // The beat currently on m_* is the last one of its input beat, so a new beat may be taken on its handshake.
  assign last_half_s = ((state_r == FIRST) && !need_second_r) || (state_r == SECOND);
  assign s_tready_s  = !rst && ((state_r == EMPTY) || (last_half_s && m.tready));
  assign accept_s    = s.tvalid && s_tready_s;
  assign drop_s      = accept_s && (s.tkeep == {IKW{1'b0}}) && !s.tlast;
  assign m_hs_s      = (state_r != EMPTY) && m.tready;

  // Next-state and load selection
  always_comb begin
    state_n_s     = state_r;
    load_first_s  = 1'b0;
    load_second_s = 1'b0;
    case (state_r)
      EMPTY: begin
        if (accept_s && !drop_s) begin
          state_n_s    = FIRST;
          load_first_s = 1'b1;
        end else begin
          state_n_s = EMPTY;
        end
      end
      FIRST: begin
        if (m_hs_s && need_second_r) begin
          state_n_s     = SECOND;
          load_second_s = 1'b1;
        end else if (m_hs_s && accept_s && !drop_s) begin
          state_n_s    = FIRST;
          load_first_s = 1'b1;
        end else if (m_hs_s) begin
          state_n_s = EMPTY;
        end else begin
          state_n_s = FIRST;
        end
      end
      SECOND: begin
        if (m_hs_s && accept_s && !drop_s) begin
          state_n_s    = FIRST;
          load_first_s = 1'b1;
        end else if (m_hs_s) begin
          state_n_s = EMPTY;
        end else begin
          state_n_s = SECOND;
        end
      end
      default: begin
        state_n_s = EMPTY;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Holding register and registered output half; an all-zero second keep means that half is never sent
  always_ff @(posedge clk) begin
    if (rst) begin
      hdata_r       <= {DW_IN{1'b0}};
      hkeep_r       <= {IKW{1'b0}};
      hlast_r       <= 1'b0;
      need_second_r <= 1'b0;
      m_tdata_r     <= {HW{1'b0}};
      m_tkeep_r     <= {HKW{1'b0}};
      m_tlast_r     <= 1'b0;
    end else if (load_first_s) begin
      hdata_r       <= s.tdata;
      hkeep_r       <= s.tkeep;
      hlast_r       <= s.tlast;
      need_second_r <= (in_second_keep_s != {HKW{1'b0}});
      m_tdata_r     <= data_half(s.tdata, FIRST_HI);
      m_tkeep_r     <= in_first_keep_s;
      m_tlast_r     <= s.tlast && (in_second_keep_s == {HKW{1'b0}});
    end else if (load_second_s) begin
      need_second_r <= 1'b0;
      m_tdata_r     <= data_half(hdata_r, ~FIRST_HI);
      m_tkeep_r     <= keep_half(hkeep_r, ~FIRST_HI);
      m_tlast_r     <= hlast_r;
    end
  end

  assign s.tready = s_tready_s;
  assign m.tvalid = (state_r != EMPTY);
  assign m.tdata  = m_tdata_r;
  assign m.tkeep  = m_tkeep_r;
  assign m.tlast  = m_tlast_r;

`ifdef STREAM_OUT_STAT_EN
  logic pkt_done_s;

  assign pkt_done_s = m_hs_s && m_tlast_r;

  stream_stat_cnt u_beats_in (
    .clk   (clk),
    .rst   (rst),
    .clr   (stat_clr),
    .inc   (accept_s),
    .count (stat_beats_in)
  );

  stream_stat_cnt u_pkts_out (
    .clk   (clk),
    .rst   (rst),
    .clr   (stat_clr),
    .inc   (pkt_done_s),
    .count (stat_pkts_out)
  );
`endif

endmodule

// File: tb/tb_stream_out_downsizer.sv
// Directed self-checking bench for stream_out_downsizer (default LSB_FIRST=1; stat checks when STREAM_OUT_STAT_EN).
module tb_stream_out_downsizer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  stream_out_downsizer_if #(.DW(128)) s_if ();
  stream_out_downsizer_if #(.DW(64))  m_if ();

`ifdef STREAM_OUT_STAT_EN
  logic        stat_clr;
  logic [31:0] stat_beats_in;
  logic [31:0] stat_pkts_out;
`endif

  stream_out_downsizer u_dut (
    .clk (clk),
    .rst (rst),
    .s   (s_if),
    .m   (m_if)
`ifdef STREAM_OUT_STAT_EN
    ,
    .stat_clr      (stat_clr),
    .stat_beats_in (stat_beats_in),
    .stat_pkts_out (stat_pkts_out)
`endif
  );

  wire [73:0] m_obs = {m_if.tvalid, m_if.tkeep, m_if.tlast, m_if.tdata};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [127:0] d, input logic [15:0] kp, input logic l);
    s_if.tvalid = v;
    s_if.tdata  = d;
    s_if.tkeep  = kp;
    s_if.tlast  = l;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_if.tready = 1'b0;
    drive(1'b0, 128'd0, 16'h0000, 1'b0);
`ifdef STREAM_OUT_STAT_EN
    stat_clr = 1'b0;
`endif
    tick();
    tick();
    n_cmp++; if (m_obs !== 74'd0) begin n_bad++; $display("FAIL reset_out got %h want %h", m_obs, 74'd0); end
    n_cmp++; if (s_if.tready !== 1'b0) begin n_bad++; $display("FAIL reset_sready got %b want 0", s_if.tready); end
`ifdef STREAM_OUT_STAT_EN
    n_cmp++; if ({stat_beats_in, stat_pkts_out} !== 64'd0) begin n_bad++; $display("FAIL reset_stat got %h want 0", {stat_beats_in, stat_pkts_out}); end
`endif
    rst = 1'b0;
    #1;
    n_cmp++; if (s_if.tready !== 1'b1) begin n_bad++; $display("FAIL idle_sready got %b want 1", s_if.tready); end
  endtask

  task automatic test_full_beat();
    m_if.tready = 1'b1;
    drive(1'b1, {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222}, 16'hFFFF, 1'b1);
    #1;
    n_cmp++; if (s_if.tready !== 1'b1) begin n_bad++; $display("FAIL full_sready got %b want 1", s_if.tready); end
    tick();
    drive(1'b0, 128'd0, 16'h0000, 1'b0);
    n_cmp++; if (m_obs !== {1'b1, 8'hFF, 1'b0, 64'h2222_2222_2222_2222}) begin n_bad++; $display("FAIL full_first got %h want %h", m_obs, {1'b1, 8'hFF, 1'b0, 64'h2222_2222_2222_2222}); end
    tick();
    n_cmp++; if (m_obs !== {1'b1, 8'hFF, 1'b1, 64'h1111_1111_1111_1111}) begin n_bad++; $display("FAIL full_second got %h want %h", m_obs, {1'b1, 8'hFF, 1'b1, 64'h1111_1111_1111_1111}); end
    tick();
    n_cmp++; if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL full_idle got %b want 0", m_if.tvalid); end
  endtask

  task automatic test_half_beat();
    m_if.tready = 1'b1;
    drive(1'b1, {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555}, 16'h00FF, 1'b1);
    tick();
    drive(1'b0, 128'd0, 16'h0000, 1'b0);
    #1;
    n_cmp++; if (m_obs !== {1'b1, 8'hFF, 1'b1, 64'h5555_5555_5555_5555}) begin n_bad++; $display("FAIL half_out got %h want %h", m_obs, {1'b1, 8'hFF, 1'b1, 64'h5555_5555_5555_5555}); end
    n_cmp++; if (s_if.tready !== 1'b1) begin n_bad++; $display("FAIL half_sready got %b want 1", s_if.tready); end
    tick();
    n_cmp++; if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL half_idle got %b want 0", m_if.tvalid); end
  endtask

  task automatic test_streaming();
    int   k = 0;
    int   j = 0;
    int   gaps = 0;
    int   rdy = 0;
    int   cyc = 0;
    logic acc;
    m_if.tready = 1'b1;
    while (j < 16 && cyc < 60) begin
      if (k < 8) drive(1'b1, {64'(2 * k + 1), 64'(2 * k)}, 16'hFFFF, (k == 7));
      else       drive(1'b0, 128'd0, 16'h0000, 1'b0);
      #1;
      acc = s_if.tvalid & s_if.tready;
      if (m_if.tvalid) begin
        if (s_if.tready) rdy++;
        n_cmp++; if (m_obs !== {1'b1, 8'hFF, (j == 15), 64'(j)}) begin n_bad++; $display("FAIL stream_beat%0d got %h want %h", j, m_obs, {1'b1, 8'hFF, (j == 15), 64'(j)}); end
        j++;
      end else if (j > 0) begin
        gaps++;
      end
      tick();
      if (acc) k++;
      cyc++;
    end
    drive(1'b0, 128'd0, 16'h0000, 1'b0);
    n_cmp++; if (j !== 16) begin n_bad++; $display("FAIL stream_count got %0d want 16", j); end
    n_cmp++; if (gaps !== 0) begin n_bad++; $display("FAIL stream_gaps got %0d want 0", gaps); end
    n_cmp++; if (rdy !== 8) begin n_bad++; $display("FAIL stream_duty got %0d want 8", rdy); end
    n_cmp++; if (k !== 8) begin n_bad++; $display("FAIL stream_accepts got %0d want 8", k); end
  endtask

  task automatic test_backpressure();
    m_if.tready = 1'b0;
    drive(1'b1, {64'hCCCC_CCCC_CCCC_CCCC, 64'h3333_3333_3333_3333}, 16'hFFFF, 1'b1);
    tick();
    drive(1'b1, {64'hDDDD_DDDD_DDDD_DDDD, 64'h4444_4444_4444_4444}, 16'hFFFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (m_obs !== {1'b1, 8'hFF, 1'b0, 64'h3333_3333_3333_3333}) begin n_bad++; $display("FAIL bp_hold%0d got %h want %h", i, m_obs, {1'b1, 8'hFF, 1'b0, 64'h3333_3333_3333_3333}); end
      n_cmp++; if (s_if.tready !== 1'b0) begin n_bad++; $display("FAIL bp_sready%0d got %b want 0", i, s_if.tready); end
      tick();
    end
    m_if.tready = 1'b1;
    #1;
    n_cmp++; if (s_if.tready !== 1'b0) begin n_bad++; $display("FAIL bp_first_sready got %b want 0", s_if.tready); end
    tick();
    n_cmp++; if (m_obs !== {1'b1, 8'hFF, 1'b1, 64'hCCCC_CCCC_CCCC_CCCC}) begin n_bad++; $display("FAIL bp_second got %h want %h", m_obs, {1'b1, 8'hFF, 1'b1, 64'hCCCC_CCCC_CCCC_CCCC}); end
    n_cmp++; if (s_if.tready !== 1'b1) begin n_bad++; $display("FAIL bp_second_sready got %b want 1", s_if.tready); end
    tick();
    drive(1'b0, 128'd0, 16'h0000, 1'b0);
    n_cmp++; if (m_obs !== {1'b1, 8'hFF, 1'b0, 64'h4444_4444_4444_4444}) begin n_bad++; $display("FAIL bp_next_first got %h want %h", m_obs, {1'b1, 8'hFF, 1'b0, 64'h4444_4444_4444_4444}); end
    tick();
    n_cmp++; if (m_obs !== {1'b1, 8'hFF, 1'b0, 64'hDDDD_DDDD_DDDD_DDDD}) begin n_bad++; $display("FAIL bp_next_second got %h want %h", m_obs, {1'b1, 8'hFF, 1'b0, 64'hDDDD_DDDD_DDDD_DDDD}); end
    tick();
    n_cmp++; if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL bp_idle got %b want 0", m_if.tvalid); end
  endtask

  task automatic test_zero_keep();
    m_if.tready = 1'b1;
    drive(1'b1, {64'h0123_4567_89AB_CDEF, 64'h1357_9BDF_2468_ACE0}, 16'h0000, 1'b0);
    tick();
    drive(1'b0, 128'd0, 16'h0000, 1'b0);
    n_cmp++; if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL zk_drop0 got %b want 0", m_if.tvalid); end
    tick();
    n_cmp++; if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL zk_drop1 got %b want 0", m_if.tvalid); end
    drive(1'b1, {64'hFEDC_BA98_7654_3210, 64'h0BAD_0BAD_0BAD_0BAD}, 16'h0000, 1'b1);
    tick();
    drive(1'b0, 128'd0, 16'h0000, 1'b0);
    n_cmp++; if (m_obs !== {1'b1, 8'h00, 1'b1, 64'h0BAD_0BAD_0BAD_0BAD}) begin n_bad++; $display("FAIL zk_last got %h want %h", m_obs, {1'b1, 8'h00, 1'b1, 64'h0BAD_0BAD_0BAD_0BAD}); end
    tick();
    n_cmp++; if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL zk_idle got %b want 0", m_if.tvalid); end
  endtask

  task automatic test_back_to_back();
    m_if.tready = 1'b1;
    drive(1'b1, {64'h0, 64'hA1A1_A1A1_A1A1_A1A1}, 16'h00FF, 1'b0);
    tick();
    drive(1'b1, {64'h0, 64'hB2B2_B2B2_B2B2_B2B2}, 16'h00FF, 1'b1);
    #1;
    n_cmp++; if (m_obs !== {1'b1, 8'hFF, 1'b0, 64'hA1A1_A1A1_A1A1_A1A1}) begin n_bad++; $display("FAIL b2b_first got %h want %h", m_obs, {1'b1, 8'hFF, 1'b0, 64'hA1A1_A1A1_A1A1_A1A1}); end
    n_cmp++; if (s_if.tready !== 1'b1) begin n_bad++; $display("FAIL b2b_sready got %b want 1", s_if.tready); end
    tick();
    drive(1'b0, 128'd0, 16'h0000, 1'b0);
    n_cmp++; if (m_obs !== {1'b1, 8'hFF, 1'b1, 64'hB2B2_B2B2_B2B2_B2B2}) begin n_bad++; $display("FAIL b2b_second got %h want %h", m_obs, {1'b1, 8'hFF, 1'b1, 64'hB2B2_B2B2_B2B2_B2B2}); end
    tick();
    n_cmp++; if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got %b want 0", m_if.tvalid); end
  endtask

  task automatic test_reset_mid();
    m_if.tready = 1'b0;
    drive(1'b1, {64'hEEEE_EEEE_EEEE_EEEE, 64'h7777_7777_7777_7777}, 16'hFFFF, 1'b1);
    tick();
    drive(1'b0, 128'd0, 16'h0000, 1'b0);
    m_if.tready = 1'b1;
    tick();
    n_cmp++; if (m_obs !== {1'b1, 8'hFF, 1'b1, 64'hEEEE_EEEE_EEEE_EEEE}) begin n_bad++; $display("FAIL rm_second got %h want %h", m_obs, {1'b1, 8'hFF, 1'b1, 64'hEEEE_EEEE_EEEE_EEEE}); end
    rst = 1'b1;
    m_if.tready = 1'b0;
    #1;
    n_cmp++; if (s_if.tready !== 1'b0) begin n_bad++; $display("FAIL rm_sready got %b want 0", s_if.tready); end
    tick();
    n_cmp++; if (m_obs !== 74'd0) begin n_bad++; $display("FAIL rm_cleared got %h want %h", m_obs, 74'd0); end
`ifdef STREAM_OUT_STAT_EN
    n_cmp++; if ({stat_beats_in, stat_pkts_out} !== 64'd0) begin n_bad++; $display("FAIL rm_stat_clr got %h want 0", {stat_beats_in, stat_pkts_out}); end
`endif
    rst = 1'b0;
    m_if.tready = 1'b1;
    drive(1'b1, {64'h9999_9999_9999_9999, 64'h8888_8888_8888_8888}, 16'hFFFF, 1'b1);
    tick();
    drive(1'b0, 128'd0, 16'h0000, 1'b0);
    n_cmp++; if (m_obs !== {1'b1, 8'hFF, 1'b0, 64'h8888_8888_8888_8888}) begin n_bad++; $display("FAIL rm_new_first got %h want %h", m_obs, {1'b1, 8'hFF, 1'b0, 64'h8888_8888_8888_8888}); end
    tick();
    n_cmp++; if (m_obs !== {1'b1, 8'hFF, 1'b1, 64'h9999_9999_9999_9999}) begin n_bad++; $display("FAIL rm_new_second got %h want %h", m_obs, {1'b1, 8'hFF, 1'b1, 64'h9999_9999_9999_9999}); end
    tick();
    n_cmp++; if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL rm_idle got %b want 0", m_if.tvalid); end
`ifdef STREAM_OUT_STAT_EN
    n_cmp++; if (stat_pkts_out !== 32'd1) begin n_bad++; $display("FAIL stat_pkts got %0d want 1", stat_pkts_out); end
    n_cmp++; if (stat_beats_in !== 32'd1) begin n_bad++; $display("FAIL stat_beats got %0d want 1", stat_beats_in); end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    n_cmp++; if ({stat_beats_in, stat_pkts_out} !== 64'd0) begin n_bad++; $display("FAIL stat_clr got %h want 0", {stat_beats_in, stat_pkts_out}); end
`endif
  endtask

  initial begin
    test_reset();
    test_full_beat();
    test_half_beat();
    test_streaming();
    test_backpressure();
    test_zero_keep();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "bench did not complete");
  end

endmodule
